reg_port_arbiter: RTL and testbench
===================================

Name: reg_port_arbiter

Overview:
- Shares one memory-style register port (req/we/addr/be/wdata, registered rdata) between two requesters, e.g. the axi2mem bridge and a debug/DMA master.
- Arbitrates per cycle, forwards the winner downstream combinationally and returns read data to the owning requester after a fixed read latency.
- Sits directly in front of the system controller register block, whose writes act on a bare we strobe.

Parameters:
- AW, 32, address width.
- DW, 64, data width.
- BEW, DW/8, byte-enable width.
- RD_LATENCY, 1, cycles from a granted read to valid i_rdata; legal range 1..4.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- i_req0  input  1  requester 0 request; held with its attributes until o_gnt0.
- i_we0  input  1  requester 0 write (1) / read (0).
- i_addr0  input  AW  requester 0 address.
- i_be0  input  BEW  requester 0 byte enables.
- i_wdata0  input  DW  requester 0 write data.
- o_gnt0  output  1  requester 0 granted this cycle.
- o_rvalid0  output  1  requester 0 read data valid.
- o_rdata0  output  DW  requester 0 read data.
- i_req1, i_we1, i_addr1, i_be1, i_wdata1, o_gnt1, o_rvalid1, o_rdata1  as above, for requester 1.
- o_req  output  1  downstream access this cycle.
- o_we  output  1  downstream write strobe; only ever high together with o_req.
- o_addr  output  AW  downstream address.
- o_be  output  BEW  downstream byte enables.
- o_wdata  output  DW  downstream write data.
- i_rdata  input  DW  downstream read data, valid RD_LATENCY cycles after a read grant.

Behaviour:
- At most one grant per cycle. o_gnt0 and o_gnt1 are combinational from the requests and the arbitration state, and are mutually exclusive.
- Round-robin arbitration:
  - A 1-bit register last records the most recent winner; reset value 1, so requester 0 wins the first contention.
  - Only one requester active: it is granted.
  - Both active: the requester not equal to last is granted.
  - last updates on every grant. No grant means last holds.
- Downstream drive:
  - o_req = o_gnt0 | o_gnt1.
  - o_we = o_req & we of the winner.
  - o_addr/o_be/o_wdata = winner's fields.
  - When idle, o_addr/o_be/o_wdata take requester 0's fields, o_req=0 and o_we=0.
- Writes complete on the grant cycle and produce no response.
- Read return:
  - A shift pipeline of RD_LATENCY stages carries {valid, owner} for each granted read; it advances every cycle.
  - At the pipeline output: o_rvalidN = valid & (owner==N), and o_rdataN registers i_rdata on that cycle. This gives a total of RD_LATENCY+1 cycles from grant to o_rvalid.
  - o_rdataN holds its value between responses.
- Back-to-back reads, with alternating or same owner, are fully pipelined at one per cycle. There is no stall and no backpressure on responses; requesters must accept o_rvalid.
- Reset values: last=1, all pipeline valid bits 0, o_rvalid0/1=0, o_rdata0/1=0.
  - Grants and o_req/o_we are 0 while rst_n=0, regardless of requests.
  - Reset mid-read drops every in-flight response; no o_rvalid pulse after reset releases.
- Simultaneous grant and pipeline output in the same cycle are independent. A new read never disturbs the response currently emerging.
- Requester dropping i_req before its grant is legal; nothing is issued for it.

Optional Feature:
- Macro REG_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins contention. last is not implemented and requester 1 is granted only when i_req0=0.
- Undefined: round-robin as above.
- Response pipeline is identical in both builds.

Test Plan:
- RD_LATENCY=1, after reset only i_req0 read at addr 0x0 → same-cycle o_gnt0=1, o_req=1, o_we=0, o_addr=0x0. i_rdata=0x00000000deadbeef driven on the next cycle. o_rvalid0=1 with o_rdata0=0x00000000deadbeef one cycle later; o_rvalid1 stays 0.
- Both request writes, req0 at 0x10 data 0x1, req1 at 0x18 data 0x55, each held until granted → cycle 0: o_gnt0, o_we=1, o_addr=0x10. Cycle 1: o_gnt1, o_we=1, o_addr=0x18. No o_rvalid.
- Both hold reads continuously for 6 cycles → grants 0,1,0,1,0,1; o_we never high.
- RD_LATENCY=3, granted reads owned 0,1,0 in consecutive cycles with i_rdata=0xA,0xB,0xC at the matching cycles → o_rvalid0/o_rvalid1/o_rvalid0 on the three consecutive cycles with rdata 0xA, 0xB, 0xC respectively.
- RD_LATENCY=3, read granted, rst_n=0 for 1 cycle one cycle later → o_rvalid0/1 remain 0 throughout. After release, the first contention grants requester 0.
- REG_ARB_FIXED_PRIO_EN defined, both requesting continuously for 4 cycles then i_req0 dropped → o_gnt0 for 4 cycles, then o_gnt1.

Source files
------------

// File: rtl/reg_port_arbiter.sv
// Two-requester arbiter for a memory-style register port with read-return routing.
// Define REG_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module reg_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 64,
   parameter int BEW        = DW/8,
   parameter int RD_LATENCY = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_req0,
   input  logic           i_we0,
   input  logic [AW-1:0]  i_addr0,
   input  logic [BEW-1:0] i_be0,
   input  logic [DW-1:0]  i_wdata0,
   output logic           o_gnt0,
   output logic           o_rvalid0,
   output logic [DW-1:0]  o_rdata0,
   input  logic           i_req1,
   input  logic           i_we1,
   input  logic [AW-1:0]  i_addr1,
   input  logic [BEW-1:0] i_be1,
   input  logic [DW-1:0]  i_wdata1,
   output logic           o_gnt1,
   output logic           o_rvalid1,
   output logic [DW-1:0]  o_rdata1,
   output logic           o_req,
   output logic           o_we,
   output logic [AW-1:0]  o_addr,
   output logic [BEW-1:0] o_be,
   output logic [DW-1:0]  o_wdata,
   input  logic [DW-1:0]  i_rdata
);

   logic                  gnt0;
   logic                  gnt1;
   logic                  rd_issue;
   logic [RD_LATENCY-1:0] pipe_v;
   logic [RD_LATENCY-1:0] pipe_own;
   logic                  out_v;
   logic                  out_own;

`ifdef REG_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         gnt0 = i_req0;
         gnt1 = i_req1 & ~i_req0;
      end
   end
`else
   // last = most recent winner; the other side wins the next contention
   logic last_q;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         if (i_req0 && i_req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
         end else begin
            gnt0 = i_req0;
            gnt1 = i_req1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else if (gnt0) begin
         last_q <= 1'b0;
      end else if (gnt1) begin
         last_q <= 1'b1;
      end
   end
`endif

   assign o_gnt0 = gnt0;
   assign o_gnt1 = gnt1;

   always_comb begin
      o_req   = gnt0 | gnt1;
      o_we    = 1'b0;
      o_addr  = i_addr0;
      o_be    = i_be0;
      o_wdata = i_wdata0;
      if (gnt1) begin
         o_we    = i_we1;
         o_addr  = i_addr1;
         o_be    = i_be1;
         o_wdata = i_wdata1;
      end else if (gnt0) begin
         o_we = i_we0;
      end
   end

   assign rd_issue = o_req & ~o_we;

   // Response tracker: one {valid, owner} slot per cycle of read latency
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe_v   <= '0;
         pipe_own <= '0;
      end else begin
         pipe_v[0]   <= rd_issue;
         pipe_own[0] <= gnt1;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_own[i] <= pipe_own[i-1];
         end
      end
   end

   assign out_v   = pipe_v[RD_LATENCY-1];
   assign out_own = pipe_own[RD_LATENCY-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_rvalid0 <= 1'b0;
         o_rvalid1 <= 1'b0;
         o_rdata0  <= '0;
         o_rdata1  <= '0;
      end else begin
         o_rvalid0 <= out_v & ~out_own;
         o_rvalid1 <= out_v & out_own;
         if (out_v && !out_own) begin
            o_rdata0 <= i_rdata;
         end
         if (out_v && out_own) begin
            o_rdata1 <= i_rdata;
         end
      end
   end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: two instances (read latency 1 and 3) share stimulus
// and are checked against a cycle-history reference model.
module tb_reg_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, addr1;
   logic [7:0]  be0, be1;
   logic [63:0] wdata0, wdata1, rdata;

   logic [1:0]        gnt0_x, gnt1_x, rv0_x, rv1_x, req_x, we_x;
   logic [1:0][31:0]  addr_x;
   logic [1:0][7:0]   be_x;
   logic [1:0][63:0]  wd_x, rd0_x, rd1_x;

   always #5 clk = ~clk;

   reg_port_arbiter #(.RD_LATENCY(1)) u_l1 (
      .clk(clk), .rst_n(rst_n),
      .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_be0(be0), .i_wdata0(wdata0),
      .o_gnt0(gnt0_x[0]), .o_rvalid0(rv0_x[0]), .o_rdata0(rd0_x[0]),
      .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_be1(be1), .i_wdata1(wdata1),
      .o_gnt1(gnt1_x[0]), .o_rvalid1(rv1_x[0]), .o_rdata1(rd1_x[0]),
      .o_req(req_x[0]), .o_we(we_x[0]), .o_addr(addr_x[0]), .o_be(be_x[0]),
      .o_wdata(wd_x[0]), .i_rdata(rdata)
   );

   reg_port_arbiter #(.RD_LATENCY(3)) u_l3 (
      .clk(clk), .rst_n(rst_n),
      .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_be0(be0), .i_wdata0(wdata0),
      .o_gnt0(gnt0_x[1]), .o_rvalid0(rv0_x[1]), .o_rdata0(rd0_x[1]),
      .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_be1(be1), .i_wdata1(wdata1),
      .o_gnt1(gnt1_x[1]), .o_rvalid1(rv1_x[1]), .o_rdata1(rd1_x[1]),
      .o_req(req_x[1]), .o_we(we_x[1]), .o_addr(addr_x[1]), .o_be(be_x[1]),
      .o_wdata(wd_x[1]), .i_rdata(rdata)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: per-cycle history of read grants, owners, resets and bus data
   int          cyc = 0;
   bit          h_rd[4096];
   bit          h_own[4096];
   bit          h_rst[4096];
   logic [63:0] h_dat[4096];
   int          lat[2] = '{1, 3};
   bit          m_last = 1'b1;
   logic        exp_g0, exp_g1, exp_req, exp_we;
   logic [31:0] exp_addr;
   logic [7:0]  exp_be;
   logic [63:0] exp_wd;
   logic        e_rv0[2], e_rv1[2];
   logic [63:0] e_rd0[2], e_rd1[2];

   task automatic settle();
      #1;
      exp_g0 = 1'b0;
      exp_g1 = 1'b0;
      if (rst_n) begin
         if (req0 && req1) begin
`ifdef REG_ARB_FIXED_PRIO_EN
            exp_g0 = 1'b1;
`else
            exp_g0 = (m_last == 1'b1);
            exp_g1 = (m_last == 1'b0);
`endif
         end else begin
            exp_g0 = req0;
            exp_g1 = req1;
         end
      end
      exp_req  = exp_g0 | exp_g1;
      exp_we   = exp_req & (exp_g1 ? we1 : we0);
      exp_addr = exp_g1 ? addr1 : addr0;
      exp_be   = exp_g1 ? be1 : be0;
      exp_wd   = exp_g1 ? wdata1 : wdata0;
   endtask

   task automatic tick();
      bit fire;
      bit own;
      @(posedge clk);
      h_rst[cyc] = !rst_n;
      h_rd[cyc]  = exp_req && !exp_we;
      h_own[cyc] = exp_g1;
      h_dat[cyc] = rdata;
      if (!rst_n) m_last = 1'b1;
      else if (exp_g0) m_last = 1'b0;
      else if (exp_g1) m_last = 1'b1;
      for (int k = 0; k < 2; k++) begin
         fire = 1'b0;
         own  = 1'b0;
         if (cyc >= lat[k] && h_rd[cyc-lat[k]]) begin
            fire = 1'b1;
            own  = h_own[cyc-lat[k]];
            for (int j = cyc - lat[k] + 1; j <= cyc; j++)
               if (h_rst[j]) fire = 1'b0;
         end
         if (h_rst[cyc]) begin
            e_rv0[k] = 1'b0;
            e_rv1[k] = 1'b0;
            e_rd0[k] = '0;
            e_rd1[k] = '0;
         end else begin
            e_rv0[k] = fire & ~own;
            e_rv1[k] = fire & own;
            if (fire && !own) e_rd0[k] = rdata;
            if (fire && own)  e_rd1[k] = rdata;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle_reqs();
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; be1 = '0; wdata1 = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; be0 = 8'hff; wdata0 = 64'h1234;
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h48; be1 = 8'h0f; wdata1 = 64'h5678;
      rdata = 64'h0;
      for (int i = 0; i < 3; i++) begin
         settle();
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if ({gnt0_x[k], gnt1_x[k], req_x[k], we_x[k]} !== 4'b0000)
               $display("FAIL reset_gnt inst%0d got %b want 0000", k,
                        {gnt0_x[k], gnt1_x[k], req_x[k], we_x[k]});
            else n_pass++;
         end
         tick();
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if ({rv0_x[k], rv1_x[k], rd0_x[k], rd1_x[k]} !== 130'd0)
               $display("FAIL reset_resp inst%0d rv=%b%b rd0=%h rd1=%h want zeros",
                        k, rv0_x[k], rv1_x[k], rd0_x[k], rd1_x[k]);
            else n_pass++;
         end
      end
      idle_reqs();
      rst_n = 1'b1;
      settle();
      tick();
   endtask

   task automatic test_write_contention();
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; be0 = 8'hff; wdata0 = 64'h1;
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h18; be1 = 8'hff; wdata1 = 64'h55;
      settle();
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if ({gnt0_x[k], gnt1_x[k], we_x[k], addr_x[k], wd_x[k]} !==
             {1'b1, 1'b0, 1'b1, 32'h10, 64'h1})
            $display("FAIL wr_first inst%0d g=%b%b we=%b addr=%h wd=%h want g0 we addr 10",
                     k, gnt0_x[k], gnt1_x[k], we_x[k], addr_x[k], wd_x[k]);
         else n_pass++;
      end
      tick();
      req0 = 1'b0;
      settle();
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if ({gnt0_x[k], gnt1_x[k], we_x[k], addr_x[k], wd_x[k]} !==
             {1'b0, 1'b1, 1'b1, 32'h18, 64'h55})
            $display("FAIL wr_second inst%0d g=%b%b we=%b addr=%h wd=%h want g1 we addr 18",
                     k, gnt0_x[k], gnt1_x[k], we_x[k], addr_x[k], wd_x[k]);
         else n_pass++;
      end
      tick();
      idle_reqs();
      for (int i = 0; i < 5; i++) begin
         settle();
         n_chk++;
         if ({rv0_x, rv1_x} !== 4'b0000)
            $display("FAIL wr_no_resp got rv0=%b rv1=%b want 0", rv0_x, rv1_x);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_contention_reads();
      req0 = 1'b1; addr0 = 32'h20; be0 = 8'hff;
      req1 = 1'b1; addr1 = 32'h28; be1 = 8'hff;
`ifdef REG_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 5; i++) begin
         if (i == 4) req0 = 1'b0;
         settle();
         n_chk++;
         if ({gnt0_x[0], gnt1_x[0], we_x[0]} !== {i < 4, i == 4, 1'b0})
            $display("FAIL fixed_prio c%0d got g=%b%b we=%b want g0=%0d", i,
                     gnt0_x[0], gnt1_x[0], we_x[0], i < 4);
         else n_pass++;
         tick();
      end
`else
      for (int i = 0; i < 6; i++) begin
         settle();
         n_chk++;
         if ({gnt0_x[0], gnt1_x[0], we_x[0]} !== {i % 2 == 0, i % 2 == 1, 1'b0})
            $display("FAIL rr_alt c%0d got g=%b%b we=%b want g0=%0d", i,
                     gnt0_x[0], gnt1_x[0], we_x[0], i % 2 == 0);
         else n_pass++;
         tick();
      end
`endif
      idle_reqs();
      for (int i = 0; i < 6; i++) begin
         settle();
         tick();
      end
   endtask

   task automatic test_single_read();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0; be0 = 8'hff;
      settle();
      n_chk++;
      if ({gnt0_x[0], req_x[0], we_x[0], addr_x[0]} !== {1'b1, 1'b1, 1'b0, 32'h0})
         $display("FAIL rd_grant got g0=%b req=%b we=%b addr=%h want 1 1 0 0",
                  gnt0_x[0], req_x[0], we_x[0], addr_x[0]);
      else n_pass++;
      tick();
      req0 = 1'b0;
      rdata = 64'h00000000deadbeef;
      settle();
      tick();
      rdata = 64'h0;
      settle();
      n_chk++;
      if ({rv0_x[0], rv1_x[0], rd0_x[0]} !== {1'b1, 1'b0, 64'h00000000deadbeef})
         $display("FAIL rd_return got rv0=%b rv1=%b rd0=%h want 1 0 deadbeef",
                  rv0_x[0], rv1_x[0], rd0_x[0]);
      else n_pass++;
      tick();
      settle();
      n_chk++;
      if ({rv0_x[0], rd0_x[0]} !== {1'b0, 64'h00000000deadbeef})
         $display("FAIL rd_hold got rv0=%b rd0=%h want 0 deadbeef", rv0_x[0], rd0_x[0]);
      else n_pass++;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_back_to_back();
      logic rv0_w, rv1_w;
      logic [63:0] d_w;
      idle_reqs();
      for (int k = 0; k < 8; k++) begin
         req0 = (k == 0 || k == 2);
         req1 = (k == 1);
         rdata = (k == 3) ? 64'hA : (k == 4) ? 64'hB : (k == 5) ? 64'hC
                 : {$urandom, $urandom};
         settle();
         tick();
         rv0_w = (k == 3 || k == 5);
         rv1_w = (k == 4);
         d_w   = (k == 3) ? 64'hA : (k == 4) ? 64'hB : 64'hC;
         n_chk++;
         if ({rv0_x[1], rv1_x[1]} !== {rv0_w, rv1_w})
            $display("FAIL b2b_valid c%0d got rv=%b%b want %b%b", k,
                     rv0_x[1], rv1_x[1], rv0_w, rv1_w);
         else n_pass++;
         if (rv0_w || rv1_w) begin
            n_chk++;
            if ((rv0_w ? rd0_x[1] : rd1_x[1]) !== d_w)
               $display("FAIL b2b_data c%0d got %h want %h", k,
                        rv0_w ? rd0_x[1] : rd1_x[1], d_w);
            else n_pass++;
         end
      end
      n_chk++;
      if ({rd0_x[1], rd1_x[1]} !== {64'hC, 64'hB})
         $display("FAIL b2b_hold got rd0=%h rd1=%h want c b", rd0_x[1], rd1_x[1]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      idle_reqs();
      req0 = 1'b1;
      settle();
      tick();
      req0 = 1'b0;
      rst_n = 1'b0;
      settle();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         settle();
         n_chk++;
         if ({rv0_x, rv1_x} !== 4'b0000)
            $display("FAIL rst_flush c%0d got rv0=%b rv1=%b want 0", i, rv0_x, rv1_x);
         else n_pass++;
         tick();
      end
      req0 = 1'b1; req1 = 1'b1;
      settle();
      n_chk++;
      if ({gnt0_x, gnt1_x} !== 4'b1100)
         $display("FAIL rst_first_win got g0=%b g1=%b want 11 00", gnt0_x, gnt1_x);
      else n_pass++;
      tick();
      idle_reqs();
      for (int i = 0; i < 5; i++) begin
         settle();
         tick();
      end
   endtask

   task automatic test_random();
      bit pend0 = 1'b0;
      bit pend1 = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!pend0 || $urandom_range(0, 15) == 0) begin
            req0 = ($urandom_range(0, 2) != 0); we0 = $urandom_range(0, 1);
            addr0 = $urandom; be0 = 8'($urandom); wdata0 = {$urandom, $urandom};
         end
         if (!pend1 || $urandom_range(0, 15) == 0) begin
            req1 = ($urandom_range(0, 2) != 0); we1 = $urandom_range(0, 1);
            addr1 = $urandom; be1 = 8'($urandom); wdata1 = {$urandom, $urandom};
         end
         rdata = {$urandom, $urandom};
         rst_n = ($urandom_range(0, 63) != 0);
         settle();
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if ({gnt0_x[k], gnt1_x[k], req_x[k], we_x[k]} !==
                {exp_g0, exp_g1, exp_req, exp_we})
               $display("FAIL rnd_ctl n%0d inst%0d got %b want %b", n, k,
                        {gnt0_x[k], gnt1_x[k], req_x[k], we_x[k]},
                        {exp_g0, exp_g1, exp_req, exp_we});
            else n_pass++;
            n_chk++;
            if ({addr_x[k], be_x[k], wd_x[k]} !== {exp_addr, exp_be, exp_wd})
               $display("FAIL rnd_bus n%0d inst%0d got %h/%h/%h want %h/%h/%h", n, k,
                        addr_x[k], be_x[k], wd_x[k], exp_addr, exp_be, exp_wd);
            else n_pass++;
            n_chk++;
            if ({rv0_x[k], rv1_x[k], rd0_x[k], rd1_x[k]} !==
                {e_rv0[k], e_rv1[k], e_rd0[k], e_rd1[k]})
               $display("FAIL rnd_resp n%0d inst%0d got %b%b %h %h want %b%b %h %h",
                        n, k, rv0_x[k], rv1_x[k], rd0_x[k], rd1_x[k],
                        e_rv0[k], e_rv1[k], e_rd0[k], e_rd1[k]);
            else n_pass++;
         end
         tick();
         pend0 = req0 && !exp_g0;
         pend1 = req1 && !exp_g1;
      end
      rst_n = 1'b1;
      idle_reqs();
   endtask

   initial begin
      idle_reqs();
      rst_n = 1'b0;
      rdata = '0;
      @(negedge clk);
      test_reset();
      test_write_contention();
      test_contention_reads();
      test_single_read();
      test_back_to_back();
      test_reset_mid_read();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
